// File: rtl/refresh_sched_if.sv
// Bundle between the DRAM refresh scheduler and the RAM controller / timebase.
// Handshake: TICK and RefAck are single-FCLK strobes with no back-pressure; RefReq/RefUrg are levels.
interface refresh_sched_if;
    logic       TICK;
    logic       RefAck;
    logic       BACT;
    logic       RefReq;
    logic       RefUrg;
    logic [2:0] RefOwed;
    logic       RefOvf;
    logic [1:0] state_dbg;

    modport master (
        output TICK, RefAck, BACT,
        input  RefReq, RefUrg, RefOwed, RefOvf, state_dbg
    );

    modport slave (
        input  TICK, RefAck, BACT,
        output RefReq, RefUrg, RefOwed, RefOvf, state_dbg
    );
endinterface

// File: rtl/refresh_sched.sv
// DRAM refresh scheduler: counts owed refreshes from a tick prescaler and raises request/urgent levels.
// Optional macro REFRESH_OVF_EN adds a sticky overflow flag for refreshes lost to saturation.
module refresh_sched #(
    parameter int TICKS_PER_REF = 8,
    parameter int URG_THRESH    = 2,
    parameter int MAX_OWED      = 7
) (
    input  logic              FCLK,
    input  logic              RES,
    refresh_sched_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        URGENT = 2'd2
    } state_t;

    localparam logic [7:0] PS_LAST  = 8'(TICKS_PER_REF - 1);
    localparam logic [2:0] MAX_C    = 3'(MAX_OWED);
    localparam logic [2:0] URG_C    = 3'(URG_THRESH);
    localparam logic [2:0] IDLE_LEN = 3'd4;

    state_t     state, state_nx;
    logic [7:0] ps, ps_nx;
    logic [2:0] owed, owed_nx;
    logic [2:0] idle_cnt, idle_nx;
    logic       promo, promo_nx;
    logic       inc;
    logic       req_q, urg_q;

    always_comb begin
        inc      = bus.TICK && (ps == PS_LAST);
        ps_nx    = ps;
        owed_nx  = owed;
        idle_nx  = 3'd0;
        promo_nx = promo;
        state_nx = IDLE;

        if (bus.TICK)
            ps_nx = inc ? 8'd0 : ps + 8'd1;

        // Simultaneous INC and RefAck cancel; saturation and empty both hold the count.
        if (inc && !bus.RefAck) begin
            if (owed != MAX_C)
                owed_nx = owed + 3'd1;
        end else if (!inc && bus.RefAck && owed != 3'd0) begin
            owed_nx = owed - 3'd1;
        end

        if (!bus.BACT)
            idle_nx = (idle_cnt == IDLE_LEN) ? idle_cnt : idle_cnt + 3'd1;

        // Idle-bus promotion latches until the owed count drains to zero.
        if (state == PEND && idle_nx == IDLE_LEN)
            promo_nx = 1'b1;
        if (owed_nx == 3'd0)
            promo_nx = 1'b0;

        if (owed_nx == 3'd0)
            state_nx = IDLE;
        else if (owed_nx >= URG_C || promo_nx)
            state_nx = URGENT;
        else
            state_nx = PEND;
    end

    always_ff @(posedge FCLK) begin
        if (RES) begin
            ps       <= 8'd0;
            owed     <= 3'd0;
            idle_cnt <= 3'd0;
            promo    <= 1'b0;
            state    <= IDLE;
            req_q    <= 1'b0;
            urg_q    <= 1'b0;
        end else begin
            ps       <= ps_nx;
            owed     <= owed_nx;
            idle_cnt <= idle_nx;
            promo    <= promo_nx;
            state    <= state_nx;
            req_q    <= (state_nx != IDLE);
            urg_q    <= (state_nx == URGENT);
        end
    end

    assign bus.RefReq    = req_q;
    assign bus.RefUrg    = urg_q;
    assign bus.RefOwed   = owed;
    assign bus.state_dbg = state;

`ifdef REFRESH_OVF_EN
    logic lost;
    logic ovf;

    assign lost = inc && !bus.RefAck && (owed == MAX_C);

    always_ff @(posedge FCLK) begin
        if (RES)
            ovf <= 1'b0;
        else if (lost)
            ovf <= 1'b1;
    end

    assign bus.RefOvf = ovf;
`else
    assign bus.RefOvf = 1'b0;
`endif
endmodule

// File: tb/tb_refresh_sched.sv
// Directed bench for refresh_sched with default parameters (8 ticks/refresh, urgent at 2, saturate at 7).
module tb_refresh_sched;
    logic fclk;
    logic res;
    int   n_cmp;
    int   n_err;

`ifdef REFRESH_OVF_EN
    localparam logic [7:0] EXP_OVF = 8'd1;
`else
    localparam logic [7:0] EXP_OVF = 8'd0;
`endif

    refresh_sched_if bus ();

    refresh_sched dut (
        .FCLK (fclk),
        .RES  (res),
        .bus  (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.TICK = 1'b1;
            step();
        end
        bus.TICK = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b1;
        step();
        res = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] owed,
                              input logic [7:0] req, input logic [7:0] urg);
        check({tag, "_owed"}, 8'(bus.RefOwed), owed);
        check({tag, "_req"},  8'(bus.RefReq),  req);
        check({tag, "_urg"},  8'(bus.RefUrg),  urg);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        res        = 1'b0;
        bus.TICK   = 1'b0;
        bus.RefAck = 1'b0;
        bus.BACT   = 1'b1;
        step();

        // Reset state
        do_reset();
        check_outs("rst", 8'd0, 8'd0, 8'd0);
        check("rst_ovf",   8'(bus.RefOvf),    8'd0);
        check("rst_state", 8'(bus.state_dbg), 8'd0);

        // First owed refresh after 8 ticks, urgent after 16
        tick_n(7);
        check("t7_owed", 8'(bus.RefOwed), 8'd0);
        tick_n(1);
        check_outs("t8", 8'd1, 8'd1, 8'd0);
        check("t8_state", 8'(bus.state_dbg), 8'd1);
        tick_n(8);
        check_outs("t16", 8'd2, 8'd1, 8'd1);
        check("t16_state", 8'(bus.state_dbg), 8'd2);

        // Saturation at 7 owed, overflow only once a refresh is actually lost
        tick_n(40);
        check("t56_owed", 8'(bus.RefOwed), 8'd7);
        check("t56_ovf",  8'(bus.RefOvf),  8'd0);
        tick_n(8);
        check("t64_owed", 8'(bus.RefOwed), 8'd7);
        check("t64_ovf",  8'(bus.RefOvf),  EXP_OVF);
        step();
        check("ovf_hold", 8'(bus.RefOvf), EXP_OVF);

        // INC and RefAck together cancel
        do_reset();
        check("rst2_ovf", 8'(bus.RefOvf), 8'd0);
        tick_n(24);
        check("t24_owed", 8'(bus.RefOwed), 8'd3);
        tick_n(7);
        bus.TICK   = 1'b1;
        bus.RefAck = 1'b1;
        step();
        bus.TICK   = 1'b0;
        bus.RefAck = 1'b0;
        check("inc_ack_owed", 8'(bus.RefOwed), 8'd3);
        bus.RefAck = 1'b1;
        step();
        bus.RefAck = 1'b0;
        check("ack3_owed", 8'(bus.RefOwed), 8'd2);

        // RefAck with nothing owed must not underflow
        do_reset();
        bus.RefAck = 1'b1;
        step();
        bus.RefAck = 1'b0;
        check_outs("ack0", 8'd0, 8'd0, 8'd0);

        // Idle-bus promotion: broken idle run does not promote
        do_reset();
        tick_n(8);
        check_outs("p1", 8'd1, 8'd1, 8'd0);
        bus.BACT = 1'b0;
        step(); step(); step();
        bus.BACT = 1'b1;
        step();
        bus.BACT = 1'b0;
        step(); step(); step();
        check("idle_broken_urg", 8'(bus.RefUrg), 8'd0);
        step();
        check("idle4_urg",   8'(bus.RefUrg),    8'd1);
        check("idle4_state", 8'(bus.state_dbg), 8'd2);
        bus.BACT = 1'b1;

        // Promotion survives a RefAck that leaves refreshes owed, clears at zero
        tick_n(8);
        check_outs("p2", 8'd2, 8'd1, 8'd1);
        bus.RefAck = 1'b1;
        step();
        bus.RefAck = 1'b0;
        check_outs("promo_hold", 8'd1, 8'd1, 8'd1);
        bus.RefAck = 1'b1;
        step();
        bus.RefAck = 1'b0;
        check_outs("promo_clr", 8'd0, 8'd0, 8'd0);
        tick_n(8);
        check_outs("promo_gone", 8'd1, 8'd1, 8'd0);

        // Reset wins over TICK and RefAck with OWED=5, PS=6
        do_reset();
        tick_n(46);
        check("pre_res_owed", 8'(bus.RefOwed), 8'd5);
        res        = 1'b1;
        bus.TICK   = 1'b1;
        bus.RefAck = 1'b1;
        step();
        res        = 1'b0;
        bus.TICK   = 1'b0;
        bus.RefAck = 1'b0;
        check_outs("res_pri", 8'd0, 8'd0, 8'd0);
        check("res_pri_ovf", 8'(bus.RefOvf), 8'd0);
        tick_n(7);
        check("ps_cleared_owed", 8'(bus.RefOwed), 8'd0);
        tick_n(1);
        check("ps_cleared_t8", 8'(bus.RefOwed), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/refresh_sched.md
REFRESH_SCHED -- requirements
Module: refresh_sched

Interface
REQ-001 SHALL have parameter TICKS_PER_REF, default 8, meaning TICK strobes per owed DRAM refresh (range 2..255).
REQ-002 SHALL have parameter URG_THRESH, default 2, meaning owed-refresh count at or above which refresh is urgent (range 1..MAX_OWED).
REQ-003 SHALL have parameter MAX_OWED, default 7, meaning saturation limit of the owed counter (range 1..7).
REQ-004 SHALL have port FCLK  input  1  FSB clock; the only clock; all state changes on its rising edge.
REQ-005 SHALL have port RES  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port TICK  input  1  single-FCLK timebase strobe, already synchronous to FCLK.
REQ-007 SHALL have port RefAck  input  1  single-FCLK pulse from the RAM controller: one refresh completed.
REQ-008 SHALL have port BACT  input  1  FSB bus cycle active; used only for the idle-hidden-refresh rule.
REQ-009 SHALL have port RefReq  output  1  at least one refresh owed.
REQ-010 SHALL have port RefUrg  output  1  refresh urgent; RAM controller must stall FSB to refresh.
REQ-011 SHALL have port RefOwed  output  3  current owed-refresh count.
REQ-012 SHALL have port RefOvf  output  1  sticky flag: a refresh was lost to saturation.

Function
REQ-013 SHALL hold an 8-bit prescaler PS; on TICK, PS = (PS==TICKS_PER_REF-1) ? 0 : PS+1; without TICK, PS holds.
REQ-014 SHALL generate internal strobe INC in the same cycle TICK arrives with PS==TICKS_PER_REF-1.
REQ-015 SHALL update the 3-bit owed counter OWED registered: INC only -> +1; RefAck only -> -1; both -> unchanged; neither -> unchanged.
REQ-016 SHALL saturate OWED at MAX_OWED: INC without RefAck at OWED==MAX_OWED leaves OWED unchanged and flags a lost refresh.
REQ-017 SHALL ignore RefAck when OWED==0 (no underflow, no wrap to 7), including when INC is simultaneously absent.
REQ-018 SHALL implement FSM states IDLE (OWED==0), PEND (1<=OWED<URG_THRESH), URGENT (OWED>=URG_THRESH); the state is registered and follows the post-update OWED value, so it may skip PEND in either direction.
REQ-019 SHALL drive RefReq=1 in PEND and URGENT, and RefUrg=1 in URGENT only; both are registered outputs reflecting the OWED value written on the same edge (one-cycle latency from INC/RefAck).
REQ-020 SHALL drive RefOwed = OWED directly from the register.
REQ-021 SHALL in PEND, when BACT has been 0 for 4 consecutive FCLK cycles, promote to URGENT (RefUrg=1) until OWED returns to 0 (hidden refresh in idle bus time); BACT=1 resets the idle count to 0.
REQ-022 SHALL leave the promotion latched through a RefAck that does not reach OWED==0, and clear it on the edge OWED becomes 0.

Reset
REQ-023 SHALL on RES=1 at a rising FCLK set PS=0, OWED=0, state IDLE, idle count 0, promotion cleared, RefOvf=0; all outputs are 0 in the following cycle.
REQ-024 SHALL give RES priority over TICK, INC and RefAck in the same cycle; a RefAck coinciding with RES is discarded.

Configuration
REQ-025 SHALL with macro REFRESH_OVF_EN defined set RefOvf on a lost refresh (REQ-016) and hold it until RES.
REQ-026 SHALL with REFRESH_OVF_EN undefined tie RefOvf to 0 and implement no overflow register; all other behaviour is identical.

Verification
REQ-027 SHALL cover: RES, then 8 TICKs -> OWED=1, RefReq=1, RefUrg=0 one cycle after the 8th TICK; 16 TICKs total -> OWED=2, RefUrg=1.
REQ-028 SHALL cover: 64 TICKs with no RefAck -> OWED saturates at 7; REFRESH_OVF_EN defined -> RefOvf=1 after the 64th TICK; undefined -> RefOvf stays 0.
REQ-029 SHALL cover: OWED=3, INC and RefAck in the same cycle -> OWED stays 3; RefAck alone at OWED=0 -> OWED stays 0.
REQ-030 SHALL cover: OWED=1, BACT=0 for 4 cycles -> RefUrg=1 on the next cycle; one RefAck -> OWED=0, RefReq=0, RefUrg=0.
REQ-031 SHALL cover: OWED=5, PS=6, RES asserted alongside TICK and RefAck -> next cycle PS=0, OWED=0, all outputs 0.
